// File: rtl/sipo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | sipo_pkg                                                              |
// | Shared frame constants and FSM state encodings for sipo_receiver.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package sipo_pkg;

  localparam int         FRAME_BITS = 10;
  localparam int         CHAR_BITS  = 8;
  localparam logic [9:0] IDLE_FRAME = 10'h3FF;
  localparam logic       START_BIT  = 1'b0;
  localparam logic       STOP_BIT   = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t START     = 3'd1;
  localparam state_t DATA      = 3'd2;
  localparam state_t STOP      = 3'd3;
  localparam state_t WAIT_IDLE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sipo_bit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | sipo_bit_timer                                                        |
// | Oversample tick counter giving mid-start and full-bit strobes.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sipo_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int CW   = $clog2(OVERSAMPLE);

  logic [CW-1:0] r_cnt;

  assign half_tick = tick && (r_cnt == CW'(HALF - 1));
  assign full_tick = tick && (r_cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      if (clear || full_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sipo_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | sipo_receiver                                                         |
// | Oversampling receiver for the 10-bit start/8-data/stop serial link.   |
// | Define SIPO_SYNC_EN to add a two-flop input synchronizer.             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_en,
  input  logic                  serial_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic [CHAR_BITS-1:0]  char_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy
);

  logic         w_rx;
  logic         w_half;
  logic         w_full;
  logic         w_clear;
  state_t       r_state;
  logic [3:0]   r_bitcnt;
  logic [CHAR_BITS:0] r_sr;

`ifdef SIPO_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], serial_in};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = serial_in;
`endif

  // Counter is pinned at zero while idle so the start edge begins the count cleanly.
  assign w_clear = (r_state == IDLE) || (r_state == WAIT_IDLE) ||
                   ((r_state == START) && w_half);

  sipo_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .tick      (sample_en),
    .clear     (w_clear),
    .half_tick (w_half),
    .full_tick (w_full)
  );

  assign busy     = (r_state != IDLE);
  assign char_out = data_out[CHAR_BITS:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_sr       <= '0;
      data_out   <= IDLE_FRAME;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample_en) begin
        case (r_state)
          IDLE: begin
            if (w_rx == START_BIT) r_state <= START;
          end
          START: begin
            if (w_half) begin
              if (w_rx == START_BIT) begin
                r_state  <= DATA;
                r_bitcnt <= '0;
                r_sr     <= {r_sr[CHAR_BITS-1:0], START_BIT};
              end else begin
                r_state <= IDLE;
              end
            end
          end
          DATA: begin
            if (w_full) begin
              r_sr     <= {r_sr[CHAR_BITS-1:0], w_rx};
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == 4'(CHAR_BITS - 1)) r_state <= STOP;
            end
          end
          STOP: begin
            if (w_full) begin
              if (w_rx == STOP_BIT) begin
                data_out   <= {r_sr, STOP_BIT};
                data_valid <= 1'b1;
                r_state    <= IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= WAIT_IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            // A held-low break must return high before another start is accepted.
            if (w_rx == STOP_BIT) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
